robo_ctrl: RTL

ROBO_CTRL -- requirements
Module: robo_ctrl

---
 rtl/robo_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/robo_ctrl.sv
// Maze-robot controller: settles after every command, samples the wall/exit/rubble
// sensors, and issues one-cycle move/turn/clear pulses, with a forward-step budget.
module robo_ctrl #(
  parameter int SETTLE    = 2,    // must be >= 1
  parameter int MAX_STEPS = 1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        head_in,
  input  logic        left_in,
  input  logic        under_in,
  input  logic        barrier_in,
  output logic        avancar,
  output logic        girar,
  output logic        remover,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [15:0] step_count
);

  typedef enum logic [2:0] {
    IDLE, WAIT, DECIDE, FWD, TURN_R, TURN_L, REMOVE, DONE
  } state_t;

  localparam int             CW        = (SETTLE > 2) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]  WAIT_LAST = CW'(SETTLE - 1);
  localparam logic [15:0]    STEP_MAX  = 16'(MAX_STEPS);

  state_t         state, state_n;
  logic           following, following_n;
  logic [1:0]     turn_cnt, turn_cnt_n;
  logic [CW-1:0]  wait_cnt, wait_cnt_n;
  logic [15:0]    step_n;
  logic           timeout_n;

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_n     = state;
    following_n = following;
    turn_cnt_n  = turn_cnt;
    wait_cnt_n  = '0;
    step_n      = step_count;
    timeout_n   = timeout;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n     = WAIT;
          following_n = 1'b0;
          turn_cnt_n  = 2'd0;
          step_n      = '0;
          timeout_n   = 1'b0;
        end
      end
      WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          // A nonzero turn count means a left turn is in progress: no resampling.
          if (turn_cnt == 2'd0) begin
            state_n = DECIDE;
          end else if (turn_cnt != 2'd3) begin
            state_n = TURN_L;
          end else if (step_count == STEP_MAX) begin
            state_n   = DONE;
            timeout_n = 1'b1;
          end else begin
            state_n = FWD;
          end
        end else begin
          wait_cnt_n = wait_cnt + 1'b1;
        end
      end
      DECIDE: begin
        if (under_in) begin
          state_n = DONE;
        end else if (barrier_in) begin
          state_n = REMOVE;
        end else if (step_count == STEP_MAX) begin
          state_n   = DONE;
          timeout_n = 1'b1;
        end else if (!following) begin
          if (!head_in) begin
            state_n = FWD;
          end else begin
            state_n     = TURN_R;
            following_n = 1'b1;
          end
        end else if (!left_in) begin
          state_n = TURN_L;
        end else if (!head_in) begin
          state_n = FWD;
        end else begin
          state_n = TURN_R;
        end
      end
      FWD: begin
        state_n    = WAIT;
        turn_cnt_n = 2'd0;
      end
      TURN_L: begin
        state_n    = WAIT;
        turn_cnt_n = turn_cnt + 2'd1;
      end
      TURN_R, REMOVE: state_n = WAIT;
      default:        state_n = IDLE;
    endcase

    // FWD is only ever entered below the budget, so the count cannot overshoot.
    if (state_n == FWD) step_n = step_count + 16'd1;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      following  <= 1'b0;
      turn_cnt   <= 2'd0;
      wait_cnt   <= '0;
      step_count <= '0;
      timeout    <= 1'b0;
      avancar    <= 1'b0;
      girar      <= 1'b0;
      remover    <= 1'b0;
    end else begin
      state      <= state_n;
      following  <= following_n;
      turn_cnt   <= turn_cnt_n;
      wait_cnt   <= wait_cnt_n;
      step_count <= step_n;
      timeout    <= timeout_n;
      avancar    <= (state_n == FWD);
      girar      <= (state_n == TURN_R) || (state_n == TURN_L);
      remover    <= (state_n == REMOVE);
    end
  end

  assign busy = (state != IDLE) && (state != DONE);
  assign done = (state == DONE);

endmodule
